// File: rtl/audio_mixer_sat.sv
// audio_mixer_sat
//   Mixes NUM_CH signed audio channels once per I2S frame and writes the
//   saturated result into a master ring buffer. The falling edge of lrclk
//   starts a mix. On that tick the samples and gains are snapshotted. A single
//   shared multiplier then handles one channel per cycle. The sum is clamped
//   to the sample range and written one slot behind the player's read index.
//
// Ports
//   mclk        in   system audio clock, all state on its rising edge
//   rst         in   synchronous active-high reset
//   lrclk       in   I2S LR clock, asynchronous; its falling edge is the sample tick
//   ch_sample   in   NUM_CH x SAMPLE_BITS signed samples, channel 0 in the LSBs
//   ch_gain     in   NUM_CH x VOLUME_BITS unsigned gains, 128 = unity
//   play_index  in   player's current read index
//   clr_flags   in   clears clip/overrun on the next edge; a new set wins
//   wr_en       out  one-cycle master buffer write strobe
//   wr_addr     out  master buffer write address, held between writes
//   wr_data     out  saturated mix, held between writes
//   busy        out  high while a mix is in progress
//   clip        out  sticky: a mix saturated
//   overrun     out  sticky: a tick arrived while busy
module audio_mixer_sat #(
    parameter int NUM_CH      = 6,
    parameter int SAMPLE_BITS = 16,
    parameter int VOLUME_BITS = 8,
    parameter int BUF_LEN     = 256
) (
    input  logic                                  mclk,
    input  logic                                  rst,
    input  logic                                  lrclk,
    input  logic [NUM_CH-1:0][SAMPLE_BITS-1:0]    ch_sample,
    input  logic [NUM_CH-1:0][VOLUME_BITS-1:0]    ch_gain,
    input  logic [$clog2(BUF_LEN)-1:0]            play_index,
    input  logic                                  clr_flags,
    output logic                                  wr_en,
    output logic [$clog2(BUF_LEN)-1:0]            wr_addr,
    output logic [SAMPLE_BITS-1:0]                wr_data,
    output logic                                  busy,
    output logic                                  clip,
    output logic                                  overrun
);
    localparam int AW     = $clog2(BUF_LEN);
    localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W  = SAMPLE_BITS + VOLUME_BITS + $clog2(NUM_CH);
    localparam int PROD_W = SAMPLE_BITS + VOLUME_BITS + 1;

    // Clamp bounds at accumulator width: 0..011..1 and its complement 1..100..0.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, SAT, WRITE} state_t;

    state_t                             state_q, state_d;
    logic                               sync1_q, sync2_q, prev_q;
    logic                               tick;
    logic [NUM_CH-1:0][SAMPLE_BITS-1:0] smp_q, smp_d;
    logic [NUM_CH-1:0][VOLUME_BITS-1:0] gain_q, gain_d;
    logic signed [ACC_W-1:0]            acc_q, acc_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               wr_en_q, wr_en_d;
    logic [AW-1:0]                      addr_q, addr_d;
    logic [SAMPLE_BITS-1:0]             data_q, data_d;
    logic                               busy_q, busy_d;
    logic                               clip_q, clip_d;
    logic                               ovr_q, ovr_d;

    // Shared multiplier datapath for the channel selected by cnt_q. The gain
    // is zero-extended into a signed operand. The full-precision product is
    // then shifted arithmetically, so negative terms round toward -inf.
    logic signed [SAMPLE_BITS-1:0] cur_s;
    logic signed [VOLUME_BITS:0]   cur_g;
    logic signed [PROD_W-1:0]      prod;
    logic signed [PROD_W-1:0]      prod_sh;
    logic signed [ACC_W-1:0]       term;
    logic [SAMPLE_BITS-1:0]        sat_val;
    logic                          clip_hit;

    assign tick = prev_q & ~sync2_q;

    always_comb begin
        cur_s   = $signed(smp_q[cnt_q]);
        cur_g   = $signed({1'b0, gain_q[cnt_q]});
        prod    = cur_s * cur_g;
        prod_sh = prod >>> 7;
        term    = ACC_W'(prod_sh);
    end

    always_comb begin
        sat_val  = acc_q[SAMPLE_BITS-1:0];
        clip_hit = 1'b0;
        if (acc_q > SAT_MAX) begin
            sat_val  = SAT_MAX[SAMPLE_BITS-1:0];
            clip_hit = 1'b1;
        end else if (acc_q < SAT_MIN) begin
            sat_val  = SAT_MIN[SAMPLE_BITS-1:0];
            clip_hit = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        gain_d  = gain_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        clip_d  = clip_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    smp_d   = ch_sample;
                    gain_d  = ch_gain;
                    addr_d  = (play_index == '0) ? AW'(BUF_LEN - 1) : play_index - AW'(1);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + term;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NUM_CH - 1)) state_d = SAT;
            end
            SAT: begin
                data_d  = sat_val;
                state_d = WRITE;
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Sticky flags: clear first so a same-cycle set overrides it.
        if (clr_flags) begin
            clip_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (state_q == SAT && clip_hit) clip_d = 1'b1;
        if (tick && state_q != IDLE)    ovr_d  = 1'b1;

        // Strobe is registered so it lines up with the freshly written data.
        wr_en_d = (state_q == SAT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            smp_q   <= '0;
            gain_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            clip_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= lrclk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            smp_q   <= smp_d;
            gain_q  <= gain_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            clip_q  <= clip_d;
            ovr_q   <= ovr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign busy    = busy_q;
    assign clip    = clip_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_audio_mixer_sat.sv
module tb_audio_mixer_sat;
    localparam int NUM_CH = 6;
    localparam int SB     = 16;
    localparam int VB     = 8;
    localparam int BL     = 256;
    localparam int AW     = $clog2(BL);
    // lrclk falls on a negedge; 2 sync edges, a tick cycle, then NUM_CH+2 cycles.
    localparam int EXP_LAT = NUM_CH + 4;

    logic                         mclk = 1'b0;
    logic                         rst;
    logic                         lrclk;
    logic [NUM_CH-1:0][SB-1:0]    ch_sample;
    logic [NUM_CH-1:0][VB-1:0]    ch_gain;
    logic [AW-1:0]                play_index;
    logic                         clr_flags;
    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    logic [SB-1:0]                wr_data;
    logic                         busy;
    logic                         clip;
    logic                         overrun;

    int checks = 0;
    int errors = 0;
    int smp [NUM_CH];
    int gn  [NUM_CH];

    audio_mixer_sat #(.NUM_CH(NUM_CH), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .BUF_LEN(BL)) dut (
        .mclk(mclk), .rst(rst), .lrclk(lrclk), .ch_sample(ch_sample), .ch_gain(ch_gain),
        .play_index(play_index), .clr_flags(clr_flags), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .clip(clip), .overrun(overrun)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sum of floor(sample*gain/128), clamped to the signed range.
    function automatic longint mix_ref(output bit clipped);
        longint sum = 0;
        longint p, q;
        longint hi = (longint'(1) << (SB - 1)) - 1;
        longint lo = -(longint'(1) << (SB - 1));
        for (int i = 0; i < NUM_CH; i++) begin
            p = longint'(smp[i]) * longint'(gn[i]);
            q = p / 128;
            if (p < 0 && (p % 128) != 0) q = q - 1;
            sum += q;
        end
        clipped = (sum > hi) || (sum < lo);
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

    function automatic longint addr_ref(input int pi);
        return (pi == 0) ? BL - 1 : pi - 1;
    endfunction

    task automatic apply();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sample[i] = SB'(smp[i]);
            ch_gain[i]   = VB'(gn[i]);
        end
    endtask

    task automatic lr_high();
        lrclk = 1'b1;
        repeat (4) @(negedge mclk);
    endtask

    task automatic clear_flags();
        @(negedge mclk); clr_flags = 1'b1;
        @(negedge mclk); clr_flags = 1'b0;
    endtask

    // Drops lrclk and watches a bounded window. mode 1 injects a second fall
    // mid-mix; mode 2 pulses rst during the third accumulate cycle.
    task automatic do_mix(input int mode, output int lat, output int pulses, output logic busy_mid);
        @(negedge mclk);
        lrclk = 1'b0;
        lat = -1; pulses = 0; busy_mid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge mclk);
            if (wr_en) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k == 5) busy_mid = busy;
            if (mode == 1 && k == 3) lrclk = 1'b1;
            if (mode == 1 && k == 5) lrclk = 1'b0;
            if (mode == 2 && k == 5) rst = 1'b1;
            if (mode == 2 && k == 6) rst = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wr_en"},   longint'(wr_en), 0);
        chk({tag, "_wr_addr"}, longint'(wr_addr), 0);
        chk({tag, "_wr_data"}, longint'(wr_data), 0);
        chk({tag, "_busy"},    longint'(busy), 0);
        chk({tag, "_clip"},    longint'(clip), 0);
        chk({tag, "_overrun"}, longint'(overrun), 0);
    endtask

    initial begin
        int lat, pulses;
        logic bm;
        bit cl;
        longint exp_d;

        rst = 1'b1; lrclk = 1'b1; clr_flags = 1'b0; play_index = '0;
        ch_sample = '0; ch_gain = '0;
        repeat (3) @(negedge mclk);
        check_outputs_zero("reset");

        // lrclk high at release must not produce a tick
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge mclk);
            if (wr_en || busy) pulses++;
        end
        chk("no_tick_after_reset", pulses, 0);

        // unity mix
        smp = '{1000, 2000, -500, 0, 0, 0};
        gn  = '{128, 128, 128, 128, 128, 128};
        play_index = AW'(10);
        apply();
        do_mix(0, lat, pulses, bm);
        chk("unity_latency", lat, EXP_LAT);
        chk("unity_pulses", pulses, 1);
        chk("unity_busy_mid", longint'(bm), 1);
        chk("unity_addr", longint'(wr_addr), 9);
        chk("unity_data", longint'($signed(wr_data)), 2500);
        chk("unity_clip", longint'(clip), 0);
        chk("unity_idle_busy", longint'(busy), 0);
        lr_high();

        // positive saturation then clear
        smp = '{20000, 20000, 20000, 20000, 20000, 20000};
        apply();
        do_mix(0, lat, pulses, bm);
        chk("pos_sat_data", longint'($signed(wr_data)), 32767);
        chk("pos_sat_clip", longint'(clip), 1);
        clear_flags();
        chk("clr_clip", longint'(clip), 0);
        chk("hold_data", longint'($signed(wr_data)), 32767);
        lr_high();

        // negative saturation at max gain
        smp = '{-32768, -32768, -32768, -32768, -32768, -32768};
        gn  = '{255, 255, 255, 255, 255, 255};
        apply();
        do_mix(0, lat, pulses, bm);
        chk("neg_sat_data", longint'($signed(wr_data)), -32768);
        chk("neg_sat_clip", longint'(clip), 1);
        clear_flags();
        lr_high();

        // half gain on one channel, zero gain elsewhere
        smp = '{100, 30000, -30000, 5, 7, 9};
        gn  = '{64, 0, 0, 0, 0, 0};
        apply();
        do_mix(0, lat, pulses, bm);
        chk("half_gain_data", longint'($signed(wr_data)), 50);
        chk("half_gain_clip", longint'(clip), 0);
        lr_high();

        // index wrap plus a second fall during accumulate
        smp = '{1234, -4321, 777, 9999, -100, 3};
        gn  = '{128, 200, 17, 90, 255, 1};
        play_index = '0;
        apply();
        exp_d = mix_ref(cl);
        do_mix(1, lat, pulses, bm);
        chk("wrap_addr", longint'(wr_addr), 255);
        chk("ovr_flag", longint'(overrun), 1);
        chk("ovr_pulses", pulses, 1);
        chk("ovr_latency", lat, EXP_LAT);
        chk("ovr_data", longint'($signed(wr_data)), exp_d);
        lr_high();

        // reset mid-mix aborts the write and clears everything
        play_index = AW'(50);
        do_mix(2, lat, pulses, bm);
        chk("abort_pulses", pulses, 0);
        check_outputs_zero("abort");
        lr_high();
        smp = '{1000, 2000, -500, 0, 0, 0};
        gn  = '{128, 128, 128, 128, 128, 128};
        apply();
        do_mix(0, lat, pulses, bm);
        chk("post_abort_latency", lat, EXP_LAT);
        chk("post_abort_addr", longint'(wr_addr), 49);
        chk("post_abort_data", longint'($signed(wr_data)), 2500);
        lr_high();

        // randomized mixes
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (it % 3 == 0) smp[i] = int'($urandom_range(0, 65535)) - 32768;
                else             smp[i] = int'($urandom_range(0, 16000)) - 8000;
                gn[i] = int'($urandom_range(0, 255));
            end
            play_index = AW'($urandom_range(0, BL - 1));
            apply();
            exp_d = mix_ref(cl);
            clear_flags();
            do_mix(0, lat, pulses, bm);
            chk($sformatf("rnd%0d_data", it), longint'($signed(wr_data)), exp_d);
            chk($sformatf("rnd%0d_addr", it), longint'(wr_addr), addr_ref(int'(play_index)));
            chk($sformatf("rnd%0d_clip", it), longint'(clip), longint'(cl));
            chk($sformatf("rnd%0d_lat", it), lat, EXP_LAT);
            lr_high();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_mixer_sat.md
AUDIO_MIXER_SAT -- requirements
Module: audio_mixer_sat

Interface
REQ-001 Parameter NUM_CH, default 6: number of mixed source channels.
REQ-002 Parameter SAMPLE_BITS, default 16: signed sample width, input and output.
REQ-003 Parameter VOLUME_BITS, default 8: unsigned per-channel gain width.
REQ-004 Parameter BUF_LEN, default 256: master buffer depth; address width is log2(BUF_LEN).
REQ-005 The block SHALL use one clock, mclk, and a synchronous, active-high reset, rst.
REQ-006 Port list:
- mclk  in  1  system audio clock; all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- lrclk  in  1  I2S LR clock, asynchronous to mclk; its falling edge is the sample tick.
- ch_sample  in  NUM_CH x SAMPLE_BITS  signed source samples, packed, channel 0 in the LSBs.
- ch_gain  in  NUM_CH x VOLUME_BITS  unsigned per-channel gains; 128 = unity.
- play_index  in  log2(BUF_LEN)  player's current read index.
- wr_en  out  1  one-cycle write strobe to the master buffer.
- wr_addr  out  log2(BUF_LEN)  master buffer write address.
- wr_data  out  SAMPLE_BITS  saturated mix result.
- busy  out  1  high while a mix is in progress.
- clip  out  1  sticky; set when any mix saturates.
- overrun  out  1  sticky; set when a tick arrives while busy.
- clr_flags  in  1  clears clip and overrun; the clear takes effect on the next rising edge.

Function
REQ-007 lrclk SHALL pass through a 2-FF synchronizer. A third register SHALL detect the falling edge. tick = prev & ~sync.
REQ-008 FSM states SHALL be IDLE, ACCUM, SAT, WRITE.
REQ-009 In IDLE, on tick, the block SHALL:
- snapshot all ch_sample and ch_gain values;
- latch wr_addr = (play_index == 0) ? BUF_LEN-1 : play_index-1;
- clear the accumulator and the channel counter;
- enter ACCUM.
REQ-010 ACCUM SHALL process one channel per cycle, channel 0 first, for exactly NUM_CH cycles, then go to SAT.
REQ-011 Each channel term SHALL be (sample * signed({0,gain})) >>> 7, arithmetic shift, full precision before the shift.
REQ-012 The accumulator width SHALL be SAMPLE_BITS+VOLUME_BITS+clog2(NUM_CH); no intermediate wrap.
REQ-013 In SAT, the result SHALL be clamped to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1], registered to wr_data, and the FSM goes to WRITE. If the clamp was applied, clip SHALL be set.
REQ-014 In WRITE, wr_en SHALL be high for exactly one cycle, then the FSM returns to IDLE.
REQ-015 Latency SHALL be fixed: wr_en asserts NUM_CH+2 cycles after the tick cycle.
REQ-016 busy SHALL be high in ACCUM, SAT and WRITE, and low in IDLE.
REQ-017 A tick outside IDLE SHALL be ignored and SHALL set overrun; the mix in progress is not disturbed.
REQ-018 If clr_flags and a set condition occur in the same cycle, set SHALL win.
REQ-019 wr_addr and wr_data SHALL hold their values between writes.
REQ-020 Gain 0 SHALL yield a zero contribution. Gain 255 SHALL yield about 1.99x.

Reset
REQ-021 On rst, all of the following SHALL clear to 0: FSM = IDLE, synchronizer and edge registers, accumulator, counter, wr_en, wr_addr, wr_data, busy, clip, overrun.
REQ-022 rst asserted mid-mix SHALL abort the mix: no wr_en is produced for it, and the flags clear.
REQ-023 The first tick after rst deasserts SHALL be processed normally. A high lrclk at reset release SHALL NOT generate a tick.

Verification
REQ-024 Unity mix: samples {1000, 2000, -500, 0, 0, 0}, all gains 128, play_index 10, lrclk falls -> one wr_en, wr_addr 9, wr_data 2500, clip 0, at tick+8 cycles.
REQ-025 Positive saturation: all six samples 20000, gains 128 -> wr_data 32767, clip 1. Then clr_flags -> clip 0.
REQ-026 Negative saturation and gain: all samples -32768, gains 255 -> wr_data -32768, clip 1. Also one sample 100 at gain 64, others at gain 0 -> wr_data 50.
REQ-027 Wrap and overrun: play_index 0 -> wr_addr 255. A second lrclk fall during ACCUM -> overrun 1, exactly one wr_en, result unchanged.
REQ-028 Reset mid-mix: rst pulsed during the 3rd ACCUM cycle -> no wr_en, all outputs 0. The next lrclk fall -> normal write.
